// File: rtl/can_pkg.sv
// can_pkg: shared CAN receive-path types and constants.
package can_pkg;

    typedef enum logic [1:0] {DS_NORMAL, DS_STUFF_EXP, DS_ERR} destuff_state_e;

    localparam int CAN_STUFF_LEN = 5;

endpackage

// File: rtl/can_bit_destuffer_if.sv
// can_bit_destuffer_if: bit stream between the RX bit sampler and the RX frame FSM.
interface can_bit_destuffer_if;

    logic sample_point;
    logic bit_destuff_en;
    logic rx_bit;
    logic rx_data_bit;
    logic rx_data_valid;
    logic stuff_bit_dropped;
    logic stuff_err;
    logic stuff_err_flag;

    modport master (
        output sample_point, bit_destuff_en, rx_bit,
        input  rx_data_bit, rx_data_valid, stuff_bit_dropped, stuff_err, stuff_err_flag
    );

    modport slave (
        input  sample_point, bit_destuff_en, rx_bit,
        output rx_data_bit, rx_data_valid, stuff_bit_dropped, stuff_err, stuff_err_flag
    );

endinterface

// File: rtl/can_sat_counter.sv
// can_sat_counter: W-bit event counter that saturates at all-ones, with synchronous clear.
module can_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt = cnt_q;

endmodule

// File: rtl/can_bit_destuffer.sv
// can_bit_destuffer: removes CAN stuff bits and flags missing stuff bits on the RX path.
// Optional saturating statistics counters are built when CAN_DESTUFF_STATS_EN is defined.
module can_bit_destuffer
    import can_pkg::*;
#(
    parameter int STUFF_LEN = CAN_STUFF_LEN
`ifdef CAN_DESTUFF_STATS_EN
    , parameter int STAT_W = 16
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reset_mode,
    can_bit_destuffer_if.slave  bus
`ifdef CAN_DESTUFF_STATS_EN
    , output logic [STAT_W-1:0] stuff_bit_cnt,
    output logic [STAT_W-1:0]   stuff_err_cnt
`endif
);

    localparam int CNT_W = $clog2(STUFF_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STUFF_LEN);

    destuff_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, run_cnt;
    logic             prev_q, prev_d;
    logic             data_q, data_d;
    logic             valid_q, valid_d;
    logic             drop_q, drop_d;
    logic             err_q, err_d;
    logic             en, bit_in;

    assign en     = bus.bit_destuff_en;
    assign bit_in = bus.rx_bit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        data_d  = data_q;
        valid_d = 1'b0;
        drop_d  = 1'b0;
        err_d   = 1'b0;
        run_cnt = (bit_in == prev_q) ? cnt_q + CNT_ONE : CNT_ONE;
        if (reset_mode) begin
            state_d = DS_NORMAL;
            cnt_d   = CNT_ONE;
            prev_d  = 1'b1;
            data_d  = 1'b1;
        end else if (bus.sample_point) begin
            case (state_q)
                DS_NORMAL: begin
                    valid_d = 1'b1;
                    data_d  = bit_in;
                    prev_d  = bit_in;
                    cnt_d   = en ? run_cnt : CNT_ONE;
                    if (en && run_cnt == CNT_MAX) state_d = DS_STUFF_EXP;
                end
                DS_STUFF_EXP: begin
                    // With destuffing off the expected stuff slot is ordinary data.
                    if (!en || bit_in != prev_q) begin
                        valid_d = !en;
                        drop_d  = en;
                        data_d  = en ? data_q : bit_in;
                        cnt_d   = CNT_ONE;
                        prev_d  = bit_in;
                        state_d = DS_NORMAL;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DS_ERR;
                    end
                end
                DS_ERR: begin
                    if (!en) begin
                        cnt_d   = CNT_ONE;
                        prev_d  = bit_in;
                        state_d = DS_NORMAL;
                    end
                end
                default: state_d = DS_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DS_NORMAL;
            cnt_q   <= CNT_ONE;
            prev_q  <= 1'b1;
            data_q  <= 1'b1;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    assign bus.rx_data_bit       = data_q;
    assign bus.rx_data_valid     = valid_q;
    assign bus.stuff_bit_dropped = drop_q;
    assign bus.stuff_err         = err_q;
    assign bus.stuff_err_flag    = state_q == DS_ERR;

`ifdef CAN_DESTUFF_STATS_EN
    // Counting the next-state pulses keeps each count aligned with its output pulse.
    can_sat_counter #(.W(STAT_W)) u_bit_cnt (
        .clk(clk), .rst_n(rst_n), .clr(reset_mode), .inc(drop_d), .cnt(stuff_bit_cnt)
    );
    can_sat_counter #(.W(STAT_W)) u_err_cnt (
        .clk(clk), .rst_n(rst_n), .clr(reset_mode), .inc(err_d), .cnt(stuff_err_cnt)
    );
`endif

endmodule

// File: tb/tb_can_bit_destuffer.sv
// tb_can_bit_destuffer: directed vector table, corner sequences and random stimulus
// against a queue-based model of the destuffing rules.
module tb_can_bit_destuffer;
    import can_pkg::*;

    localparam int N = CAN_STUFF_LEN;
`ifdef CAN_DESTUFF_STATS_EN
    localparam int SW = 4;
    logic [SW-1:0] sbc, sec;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic reset_mode = 1'b0;

    can_bit_destuffer_if bus();

`ifdef CAN_DESTUFF_STATS_EN
    can_bit_destuffer #(.STAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .reset_mode(reset_mode), .bus(bus),
        .stuff_bit_cnt(sbc), .stuff_err_cnt(sec)
    );
`else
    can_bit_destuffer dut (
        .clk(clk), .rst_n(rst_n), .reset_mode(reset_mode), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic       rm;
        logic       sp;
        logic       en;
        logic       b;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    // Model: the bits of the current run window, plus error and output state.
    bit   hist[$];
    bit   in_err;
    logic m_data, m_valid, m_drop, m_err;
    int   nb, ne;

    function automatic bit stuff_due();
        if (hist.size() < N) return 1'b0;
        for (int i = hist.size() - N; i < hist.size(); i++)
            if (hist[i] != hist[hist.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic restart(input bit b);
        hist.delete();
        hist.push_back(b);
    endtask

    task automatic model(input logic rm, input logic sp, input logic en, input logic b);
        m_valid = 1'b0;
        m_drop  = 1'b0;
        m_err   = 1'b0;
        if (rm) begin
            restart(1'b1);
            in_err = 1'b0;
            m_data = 1'b1;
            nb = 0;
            ne = 0;
        end else if (sp) begin
            if (in_err) begin
                if (!en) begin
                    in_err = 1'b0;
                    restart(b);
                end
            end else if (stuff_due()) begin
                if (!en) begin
                    m_valid = 1'b1;
                    m_data  = b;
                    restart(b);
                end else if (b != hist[hist.size() - 1]) begin
                    m_drop = 1'b1;
                    nb++;
                    restart(b);
                end else begin
                    m_err  = 1'b1;
                    in_err = 1'b1;
                    ne++;
                end
            end else begin
                m_valid = 1'b1;
                m_data  = b;
                if (!en) restart(b);
                else hist.push_back(b);
                if (hist.size() > N) void'(hist.pop_front());
            end
        end
    endtask

    function automatic int sat(input int n);
`ifdef CAN_DESTUFF_STATS_EN
        return (n > (1 << SW) - 1) ? (1 << SW) - 1 : n;
`else
        return n;
`endif
    endfunction

    function automatic logic [4:0] dut_out();
        return {bus.rx_data_bit, bus.rx_data_valid, bus.stuff_bit_dropped,
                bus.stuff_err, bus.stuff_err_flag};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic rm, input logic sp, input logic en, input logic b);
        @(negedge clk);
        reset_mode       = rm;
        bus.sample_point = sp;
        bus.bit_destuff_en = en;
        bus.rx_bit       = b;
        @(posedge clk);
        model(rm, sp, en, b);
        #1;
        check("model", dut_out(), {m_data, m_valid, m_drop, m_err, in_err});
`ifdef CAN_DESTUFF_STATS_EN
        check("stuff_bit_cnt", sbc, sat(nb));
        check("stuff_err_cnt", sec, sat(ne));
`endif
    endtask

    task automatic add(input logic rm, input logic sp, input logic en, input logic b,
                       input logic [4:0] exp);
        vec_t v;
        v.rm = rm; v.sp = sp; v.en = en; v.b = b; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        int   nv;
        logic lb;
        // Outputs are {rx_data_bit, valid, dropped, err, err_flag}.
        add(0,1,0,0,5'b01000);
        repeat (4) add(0,1,1,0,5'b01000);
        add(0,1,1,1,5'b00100);
        repeat (4) add(0,1,1,1,5'b11000);
        add(0,1,1,0,5'b10100);
        add(0,1,0,1,5'b11000);
        add(0,1,0,0,5'b01000);
        repeat (4) add(0,1,1,0,5'b01000);
        add(0,1,1,0,5'b00011);
        add(0,1,1,1,5'b00001);
        add(0,1,1,0,5'b00001);
        add(0,1,0,1,5'b00000);
        add(0,0,0,1,5'b00000);
        add(0,1,0,0,5'b01000);
        repeat (4) add(0,1,1,0,5'b01000);
        add(0,1,0,0,5'b01000);
        add(0,1,1,1,5'b11000);
        add(0,1,0,0,5'b01000);
        repeat (3) add(0,1,1,0,5'b01000);
        add(1,1,1,0,5'b10000);
        repeat (5) add(0,1,1,0,5'b01000);
        add(0,1,1,1,5'b00100);

        bus.sample_point = 1'b1;
        bus.bit_destuff_en = 1'b1;
        bus.rx_bit = 1'b0;
        model(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset", dut_out(), 5'b10000);
        @(negedge clk);
        bus.sample_point = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rm, vecs[i].sp, vecs[i].en, vecs[i].b);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        step(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, i[1], i[0]);
        nv = 0;
        step(0, 1, 0, 0);
        nv += int'(bus.rx_data_valid);
        repeat (3) begin
            step(0, 0, 0, 1);
            nv += int'(bus.rx_data_valid);
        end
        check("single_valid", nv, 1);

`ifdef CAN_DESTUFF_STATS_EN
        lb = 1'b0;
        step(1, 0, 0, 0);
        step(0, 1, 0, lb);
        for (int k = 0; k < 17; k++) begin
            repeat (4) step(0, 1, 1, lb);
            lb = ~lb;
            step(0, 1, 1, lb);
        end
        check("stat_sat", sbc, 4'hF);
        step(1, 0, 0, 0);
        check("stat_clr", sbc, 4'h0);
`endif

        lb = 1'b1;
        step(1, 1, 0, 1);
        for (int i = 0; i < 800; i++) begin
            lb = ($urandom_range(0, 5) == 0) ? ~lb : lb;
            step(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 9) != 0), lb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
